// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: FSM state type and counter width shared by the FIFO burst reader.
package fifo_rd_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT_FILL, BURST, FLUSH} rd_state_e;
endpackage

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains fixed-length bursts from an FWFT FIFO onto a registered valid/ready stream.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_bursts,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_pre_fill_done,
  input  logic [ADDR_WIDTH:0]   fifo_rd_level,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int WC_W = $clog2(BURST_LEN + 1);
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] LEVEL_MIN = (ADDR_WIDTH + 1)'(BURST_LEN);
  rd_state_e state_q, state_d;
  logic [CNT_W-1:0] bursts_left_q, bursts_left_d, stall_q, stall_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic first_q, first_d, done_q, done_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic pop, last_pop;
  // A pop needs the output register free or draining this cycle.
  assign pop = state_q == BURST && !fifo_empty && (!m_valid_q || m_ready);
  assign last_pop = pop && word_cnt_q == LAST_IDX;
  assign fifo_rd_en = pop;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign stall_cnt = stall_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_last = m_last_q;
  always_comb begin
    state_d = state_q;
    bursts_left_d = bursts_left_q;
    stall_d = stall_q;
    word_cnt_d = word_cnt_q;
    first_d = first_q;
    done_d = 1'b0;
    m_valid_d = pop || (m_valid_q && !m_ready);
    m_data_d = pop ? fifo_rd_data : m_data_q;
    m_last_d = pop ? last_pop : m_last_q;
    case (state_q)
      IDLE: begin
        if (start && num_bursts != '0) begin
          bursts_left_d = num_bursts;
          stall_d = '0;
          word_cnt_d = '0;
          first_d = 1'b1;
          state_d = WAIT_FILL;
        end
        done_d = start && num_bursts == '0;
      end
      WAIT_FILL: begin
        if (fifo_rd_level >= LEVEL_MIN && (!first_q || fifo_pre_fill_done)) begin
          first_d = 1'b0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (fifo_empty && stall_q != '1) stall_d = stall_q + 1'b1;
        if (pop) word_cnt_d = last_pop ? '0 : word_cnt_q + 1'b1;
        if (last_pop) begin
          bursts_left_d = bursts_left_q - 1'b1;
          state_d = bursts_left_q == CNT_W'(1) ? FLUSH : WAIT_FILL;
        end
      end
      FLUSH: begin
        if (m_valid_q && m_ready) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= IDLE;
      bursts_left_q <= '0;
      stall_q <= '0;
      word_cnt_q <= '0;
      first_q <= 1'b0;
      done_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bursts_left_q <= bursts_left_d;
      stall_q <= stall_d;
      word_cnt_q <= word_cnt_d;
      first_q <= first_d;
      done_q <= done_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard of expected stream words plus done/busy job model, with directed scenarios.
module tb_fifo_burst_reader;
  localparam int BL = 4;
  logic rd_clk = 0, rd_rst = 1, start = 0, fifo_pre_fill_done = 0, m_ready = 1, force_empty = 0;
  logic [15:0] num_bursts = 0;
  logic busy, done, fifo_rd_en, fifo_empty, m_valid, m_last;
  logic [15:0] stall_cnt;
  logic [7:0] fifo_rd_data, m_data;
  logic [4:0] fifo_rd_level;
  logic [7:0] mem [256];
  logic [7:0] rp = 0, wp = 0;
  logic [8:0] exp_q[$];
  logic [7:0] hs_data[$];
  int hs_cyc[$];
  int checks = 0, errors = 0, cyc = 0, done_cyc = -1;
  logic done_due = 0, busy_exp = 0, pv = 0, pr = 0, pl = 0, fin = 0;
  logic [7:0] pd = 0;

  fifo_burst_reader #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .BURST_LEN(BL)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .num_bursts(num_bursts),
    .busy(busy), .done(done), .stall_cnt(stall_cnt), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_pre_fill_done(fifo_pre_fill_done), .fifo_rd_level(fifo_rd_level),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_rd_data = mem[rp];
  assign fifo_empty = force_empty || rp == wp;
  assign fifo_rd_level = force_empty ? 5'd0 : 5'(wp - rp);
  always @(posedge rd_clk) if (fifo_rd_en) rp <= rp + 8'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  // Sampled mid-cycle, after the negedge stimulus settles: values shown here are what the next posedge sees.
  always begin
    @(negedge rd_clk);
    #1;
    cyc++;
    if (rd_rst) begin
      exp_q.delete();
      done_due = 0;
      busy_exp = 0;
      pv = 0;
    end else begin
      chk("done", done, done_due);
      chk("busy", busy, busy_exp);
      if (done) done_cyc = cyc;
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      if (fifo_rd_en) chk("rd_en_legal", !fifo_empty && busy && (!m_valid || m_ready), 1);
      fin = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word got %0h want none", m_data);
        end else begin
          chk("stream_word", {m_last, m_data}, exp_q.pop_front());
          fin = exp_q.size() == 0;
        end
        hs_data.push_back(m_data);
        hs_cyc.push_back(cyc);
      end
      done_due = fin || (start && !busy_exp && num_bursts == 0);
      if (start && !busy_exp && num_bursts != 0) busy_exp = 1;
      if (fin) busy_exp = 0;
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
    end
  end

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = base + 8'(i);
      wp = wp + 8'd1;
    end
  endtask

  task automatic go(input logic [15:0] n, input logic [7:0] base);
    @(negedge rd_clk);
    start = 1;
    num_bursts = n;
    if (!busy)
      for (int i = 0; i < int'(n) * BL; i++) exp_q.push_back({i % BL == BL - 1, base + 8'(i)});
    @(negedge rd_clk);
    start = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge rd_clk);
      n++;
    end
    chk(nm, n < 300, 1);
    repeat (2) @(negedge rd_clk);
  endtask

  initial begin
    int n0, r0;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge rd_clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(negedge rd_clk);
    rd_rst = 0;
    repeat (2) @(negedge rd_clk);

    fifo_pre_fill_done = 1;
    fill(8'h10, 8);
    go(2, 8'h10);
    wait_idle("basic_timeout");
    chk("basic_count", hs_cyc.size(), 8);
    if (hs_cyc.size() == 8) begin
      chk("basic_first", hs_data[0], 8'h10);
      chk("basic_last", hs_data[7], 8'h17);
      chk("basic_span0", hs_cyc[3] - hs_cyc[0], 3);
      chk("basic_span1", hs_cyc[7] - hs_cyc[4], 3);
      chk("basic_gap", hs_cyc[4] - hs_cyc[3] >= 2, 1);
      chk("basic_done_lat", done_cyc - hs_cyc[7], 1);
    end
    chk("basic_stall", stall_cnt, 0);

    n0 = hs_data.size();
    fill(8'h30, 4);
    go(1, 8'h30);
    for (int n = 0; n < 100 && (busy || exp_q.size() != 0); n++) begin
      @(negedge rd_clk);
      m_ready = ~m_ready;
    end
    m_ready = 1;
    wait_idle("bp_timeout");
    chk("bp_words", hs_data.size() - n0, 4);

    fifo_pre_fill_done = 0;
    fill(8'h20, 8);
    go(2, 8'h20);
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      start = i == 2;
      num_bursts = 3;
      #1 chk("prefill_hold", fifo_rd_en, 0);
    end
    @(negedge rd_clk);
    start = 0;
    fifo_pre_fill_done = 1;
    #1 seen = fifo_rd_en;
    @(negedge rd_clk);
    #1 seen = seen | fifo_rd_en;
    chk("prefill_first_pop", seen, 1);
    wait_idle("prefill_timeout");

    r0 = int'(rp);
    fill(8'h40, 4);
    go(1, 8'h40);
    for (int n = 0; n < 50 && rp != 8'(r0 + 2); n++) @(negedge rd_clk);
    chk("underrun_reach", rp, 8'(r0 + 2));
    force_empty = 1;
    repeat (3) @(negedge rd_clk);
    force_empty = 0;
    wait_idle("underrun_timeout");
    chk("underrun_stall", stall_cnt, 3);

    go(0, 8'h00);
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge rd_clk);
    #1 chk("zero_done_once", done, 0);

    fill(8'h50, 8);
    go(2, 8'h50);
    for (int n = 0; n < 50 && !m_valid; n++) @(negedge rd_clk);
    chk("mid_reached", m_valid, 1);
    rd_rst = 1;
    #1;
    chk("mid_m_valid", m_valid, 0);
    chk("mid_m_data", m_data, 0);
    chk("mid_m_last", m_last, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_rd_en", fifo_rd_en, 0);
    chk("mid_stall", stall_cnt, 0);
    @(negedge rd_clk);
    rd_rst = 0;
    repeat (4) begin
      @(negedge rd_clk);
      #1;
      chk("mid_no_done", done, 0);
      chk("mid_idle", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
